// File: rtl/instr_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_responder_pkg                                              |
// | Shared response-code definitions for the instruction fetch port.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package instr_mem_responder_pkg;

    localparam int c_rresp_w = 2;

    typedef enum logic [c_rresp_w-1:0] {
        RRESP_OKAY         = 2'b00,
        RRESP_MISALIGNED   = 2'b10,
        RRESP_OUT_OF_RANGE = 2'b11
    } rresp_e;

endpackage
`default_nettype wire

// File: rtl/instr_mem_responder_resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | resp_fifo                                                            |
// | Two-entry synchronous response FIFO with a single-cycle flush.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module resp_fifo #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_data [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign w_push = i_push && (r_count != 2'd2);
    assign w_pop  = i_pop  && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (!rstn || i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_pop_data = r_data[r_rd_ptr];
    assign o_count    = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instr_mem_responder                                                  |
// | Instruction memory with valid/ready fetch port and image-load port.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module instr_mem_responder #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [XLEN-1:0]          i_im_raddr,
    input  logic                     i_im_rvalid,
    output logic                     o_im_rready,
    output logic [XLEN-1:0]          o_im_rdata,
    output logic [1:0]               o_im_rresp,
    output logic                     o_im_dvalid,
    input  logic                     i_im_dready,
    input  logic                     i_flush,
    input  logic                     i_ld_en,
    input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
    input  logic [XLEN-1:0]          i_ld_data
);

    import instr_mem_responder_pkg::*;

    localparam int              c_aw    = $clog2(DEPTH);
    localparam int              c_ew    = c_rresp_w + XLEN;
    localparam logic [XLEN-1:0] c_depth = XLEN'(DEPTH);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic            r_ready_en;
    logic [1:0]      w_cnt;
    logic [XLEN-1:0] w_off;
    logic [XLEN-1:0] w_word;
    rresp_e          w_resp;
    logic [XLEN-1:0] w_rdata;
    logic            w_accept;
    logic            w_retire;
    logic [c_ew-1:0] w_head;

    // Holds the port closed while in reset and opens it on the first clean edge.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // Memory contents survive reset; the load port runs alongside fetches.
    always_ff @(posedge clk) begin
        if (i_ld_en) begin
            r_mem[i_ld_addr] <= i_ld_data;
        end
    end

    assign w_off  = i_im_raddr - BASE_ADDR;
    assign w_word = w_off >> 2;

    // The response is formed from the pre-edge array value, so a load to the
    // same word in the accept cycle is seen only by later reads.
    always_comb begin
        w_resp  = RRESP_OKAY;
        w_rdata = r_mem[w_word[c_aw-1:0]];
        if ((i_im_raddr < BASE_ADDR) || (w_word >= c_depth)) begin
            w_resp  = RRESP_OUT_OF_RANGE;
            w_rdata = '0;
        end else if (i_im_raddr[1:0] != 2'b00) begin
            w_resp  = RRESP_MISALIGNED;
            w_rdata = '0;
        end
    end

    assign o_im_rready = r_ready_en && (w_cnt < 2'd2) && !i_flush;
    assign w_accept    = i_im_rvalid && o_im_rready;
    assign w_retire    = o_im_dvalid && i_im_dready;

    resp_fifo #(
        .WIDTH (c_ew)
    ) u_resp_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .i_flush     (i_flush),
        .i_push      (w_accept),
        .i_push_data ({w_resp, w_rdata}),
        .i_pop       (w_retire),
        .o_pop_data  (w_head),
        .o_count     (w_cnt)
    );

    assign o_im_dvalid = (w_cnt != 2'd0);
    assign o_im_rdata  = o_im_dvalid ? w_head[XLEN-1:0]    : '0;
    assign o_im_rresp  = o_im_dvalid ? w_head[c_ew-1:XLEN] : '0;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_instr_mem_responder                                               |
// | Vector table plus scoreboard bench for the instruction responder.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_instr_mem_responder;

    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] MIS = 2'b10;
    localparam logic [1:0] OOR = 2'b11;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] i_im_raddr;
    logic        i_im_rvalid;
    logic        o_im_rready;
    logic [31:0] o_im_rdata;
    logic [1:0]  o_im_rresp;
    logic        o_im_dvalid;
    logic        i_im_dready;
    logic        i_flush;
    logic        i_ld_en;
    logic [9:0]  i_ld_addr;
    logic [31:0] i_ld_data;

    exp_t sb[$];
    exp_t cur_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vt [10];

    instr_mem_responder dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_im_raddr  (i_im_raddr),
        .i_im_rvalid (i_im_rvalid),
        .o_im_rready (o_im_rready),
        .o_im_rdata  (o_im_rdata),
        .o_im_rresp  (o_im_rresp),
        .o_im_dvalid (o_im_dvalid),
        .i_im_dready (i_im_dready),
        .i_flush     (i_flush),
        .i_ld_en     (i_ld_en),
        .i_ld_addr   (i_ld_addr),
        .i_ld_data   (i_ld_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven for the next rising edge.
    task automatic step();
        exp_t e;
        #1;
        if (o_im_dvalid && i_im_dready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_response: got rdata %h rresp %b, expected none",
                         o_im_rdata, o_im_rresp);
            end else begin
                e = sb.pop_front();
                chk("resp_data", o_im_rdata, e.data);
                chk("resp_code", 32'(o_im_rresp), 32'(e.resp));
            end
        end
        if (i_im_rvalid && o_im_rready) sb.push_back(cur_exp);
        @(posedge clk);
        if (i_flush || !rstn) sb.delete();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [31:0] a, input logic [1:0] r, input logic [31:0] d);
        i_im_raddr  = a;
        i_im_rvalid = 1'b1;
        cur_exp     = '{resp: r, data: d};
    endtask

    task automatic load(input logic [9:0] idx, input logic [31:0] d);
        i_ld_en   = 1'b1;
        i_ld_addr = idx;
        i_ld_data = d;
        step();
        i_ld_en   = 1'b0;
    endtask

    task automatic drain();
        i_im_rvalid = 1'b0;
        i_im_dready = 1'b1;
        for (int k = 0; k < 8 && sb.size() != 0; k++) step();
        chk("drain_pending", 32'(sb.size()), 32'd0);
        #1;
        chk("drain_dvalid", 32'(o_im_dvalid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt = '{
            '{32'h0000_0000, OK,  32'h0000_0013},
            '{32'h0000_0004, OK,  32'h0010_0093},
            '{32'h0000_0008, OK,  32'h0020_0113},
            '{32'h0000_000C, OK,  32'h0030_0193},
            '{32'h0000_0006, MIS, 32'h0000_0000},
            '{32'h0000_1000, OOR, 32'h0000_0000},
            '{32'hFFFF_FFFE, OOR, 32'h0000_0000},
            '{32'h0000_0FFC, OK,  32'hCAFE_F00D},
            '{32'h0000_1001, OOR, 32'h0000_0000},
            '{32'h0000_0003, MIS, 32'h0000_0000}
        };

        rstn        = 1'b0;
        i_im_raddr  = '0;
        i_im_rvalid = 1'b0;
        i_im_dready = 1'b0;
        i_flush     = 1'b0;
        i_ld_en     = 1'b0;
        i_ld_addr   = '0;
        i_ld_data   = '0;
        cur_exp     = '0;

        step();
        step();
        #1;
        chk("reset_dvalid", 32'(o_im_dvalid), 32'd0);
        chk("reset_rdata",  o_im_rdata, 32'd0);
        chk("reset_rresp",  32'(o_im_rresp), 32'd0);
        chk("reset_rready", 32'(o_im_rready), 32'd0);
        rstn = 1'b1;
        step();
        #1;
        chk("post_reset_rready", 32'(o_im_rready), 32'd1);

        load(10'd0,   32'h0000_0013);
        load(10'd1,   32'h0010_0093);
        load(10'd2,   32'h0020_0113);
        load(10'd3,   32'h0030_0193);
        load(10'd1023, 32'hCAFE_F00D);

        // Back-to-back fetches with the consumer always ready.
        i_im_dready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_req(vt[i].addr, vt[i].resp, vt[i].data);
            #1;
            chk("rready_sustained", 32'(o_im_rready), 32'd1);
            chk("dvalid_latency", 32'(o_im_dvalid), (i == 0) ? 32'd0 : 32'd1);
            step();
        end
        drain();

        // Backpressure: two outstanding, output held stable.
        i_im_dready = 1'b0;
        set_req(32'h0, OK, 32'h0000_0013);
        step();
        set_req(32'h4, OK, 32'h0010_0093);
        step();
        i_im_rvalid = 1'b0;
        #1;
        chk("full_rready", 32'(o_im_rready), 32'd0);
        chk("hold_dvalid", 32'(o_im_dvalid), 32'd1);
        chk("hold_rdata",  o_im_rdata, 32'h0000_0013);
        step();
        #1;
        chk("hold_rdata_2",  o_im_rdata, 32'h0000_0013);
        chk("hold_rresp_2",  32'(o_im_rresp), 32'(OK));
        chk("full_rready_2", 32'(o_im_rready), 32'd0);
        i_im_dready = 1'b1;
        step();
        step();
        #1;
        chk("rready_return", 32'(o_im_rready), 32'd1);
        chk("empty_dvalid",  32'(o_im_dvalid), 32'd0);

        // Load and read of the same word in one cycle.
        i_ld_en   = 1'b1;
        i_ld_addr = 10'd1;
        i_ld_data = 32'hDEAD_BEEF;
        set_req(32'h4, OK, 32'h0010_0093);
        step();
        i_ld_en = 1'b0;
        set_req(32'h4, OK, 32'hDEAD_BEEF);
        step();
        drain();

        // Flush with two responses outstanding.
        i_im_dready = 1'b0;
        set_req(32'h0, OK, 32'h0000_0013);
        step();
        set_req(32'h4, OK, 32'hDEAD_BEEF);
        step();
        set_req(32'hC, OK, 32'h0030_0193);
        i_flush = 1'b1;
        #1;
        chk("flush_rready", 32'(o_im_rready), 32'd0);
        step();
        i_flush     = 1'b0;
        i_im_rvalid = 1'b0;
        #1;
        chk("flush_dvalid", 32'(o_im_dvalid), 32'd0);
        step();
        #1;
        chk("flush_dvalid_2", 32'(o_im_dvalid), 32'd0);
        i_im_dready = 1'b1;
        set_req(32'h8, OK, 32'h0020_0113);
        step();
        drain();

        // Reset in the middle of traffic.
        i_im_dready = 1'b0;
        set_req(32'h0, OK, 32'h0000_0013);
        step();
        set_req(32'h8, OK, 32'h0020_0113);
        step();
        i_im_rvalid = 1'b0;
        rstn        = 1'b0;
        step();
        #1;
        chk("midrst_dvalid", 32'(o_im_dvalid), 32'd0);
        chk("midrst_rdata",  o_im_rdata, 32'd0);
        chk("midrst_rresp",  32'(o_im_rresp), 32'd0);
        chk("midrst_rready", 32'(o_im_rready), 32'd0);
        rstn = 1'b1;
        step();
        #1;
        chk("midrst_rready_back", 32'(o_im_rready), 32'd1);
        i_im_dready = 1'b1;
        set_req(32'hC, OK, 32'h0030_0193);
        step();
        set_req(32'h4, OK, 32'hDEAD_BEEF);
        step();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_mem_responder.md
INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/data width.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning number of XLEN-bit words stored.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port rstn, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port i_im_raddr, input, XLEN, fetch byte address.
REQ-007 SHALL have port i_im_rvalid, input, 1, request valid.
REQ-008 SHALL have port o_im_rready, output, 1, request accept ready.
REQ-009 SHALL have port o_im_rdata, output, XLEN, instruction word.
REQ-010 SHALL have port o_im_rresp, output, 2, response code: 00 OKAY, 10 MISALIGNED, 11 OUT_OF_RANGE.
REQ-011 SHALL have port o_im_dvalid, output, 1, response valid.
REQ-012 SHALL have port i_im_dready, input, 1, response consumer ready.
REQ-013 SHALL have port i_flush, input, 1, discard all pending/in-flight responses.
REQ-014 SHALL have port i_ld_en, input, 1, image-load write strobe.
REQ-015 SHALL have port i_ld_addr, input, $clog2(DEPTH), image-load word index.
REQ-016 SHALL have port i_ld_data, input, XLEN, image-load word.

Function
REQ-017 SHALL accept a request on a cycle where i_im_rvalid && o_im_rready.
REQ-018 SHALL present the response for an accepted request no earlier than the following cycle (1-cycle read latency), in acceptance order.
REQ-019 SHALL hold o_im_rdata/o_im_rresp stable while o_im_dvalid && !i_im_dready.
REQ-020 SHALL retire a response on o_im_dvalid && i_im_dready.
REQ-021 SHALL track occupancy CNT (0..2) = in-flight reads + buffered responses; +1 on accept, -1 on retire, both same cycle -> unchanged.
REQ-022 SHALL drive o_im_rready = (CNT < 2) && !i_flush, giving 1 request/cycle sustained when i_im_dready stays high.
REQ-023 SHALL report OUT_OF_RANGE with rdata 0 when i_im_raddr < BASE_ADDR or (i_im_raddr - BASE_ADDR) >> 2 >= DEPTH.
REQ-024 SHALL report MISALIGNED with rdata 0 when i_im_raddr[1:0] != 0 and the address is in range; OUT_OF_RANGE takes priority.
REQ-025 SHALL otherwise return mem[(i_im_raddr - BASE_ADDR) >> 2] with OKAY.
REQ-026 SHALL write i_ld_data to mem[i_ld_addr] on i_ld_en, concurrently with reads.
REQ-027 SHALL return old data (read-before-write) when a load and an accepted read target the same word in the same cycle.
REQ-028 SHALL, on i_flush, force CNT to 0 and o_im_dvalid low on the next cycle; a request is never accepted in the flush cycle; a retire in the flush cycle still completes.
REQ-029 SHALL never emit a response for a request accepted before a flush.

Reset
REQ-030 SHALL, while rstn is low at a clock edge, set CNT 0, o_im_dvalid 0, o_im_rdata 0, o_im_rresp 00, o_im_rready 0.
REQ-031 SHALL assert o_im_rready in the first cycle after rstn is high (if i_flush low).
REQ-032 SHALL not reset memory contents; reset mid-operation discards all pending responses.

Structure
REQ-033 SHALL take the rresp enum (OKAY/MISALIGNED/OUT_OF_RANGE) and its width constant from a shared core package.
REQ-034 SHALL buffer responses in one sub-module, resp_fifo (2-entry synchronous FIFO with flush input).

Verification
REQ-035 Load mem[0..3]=32'h00000013,32'h00100093,32'h00200113,32'h00300193; request 0x0,0x4,0x8,0xC back-to-back, dready=1 -> four OKAY responses in order on consecutive cycles, rready never drops.
REQ-036 Accept 0x0 and 0x4 with dready=0 -> CNT=2, rready=0, dvalid holds 32'h00000013 stable; raise dready -> both retire in order, rready returns.
REQ-037 Request 0x6 -> rresp=10, rdata=0; request BASE_ADDR+4*DEPTH (0x1000) -> rresp=11, rdata=0; request 0xFFFF_FFFE -> rresp=11.
REQ-038 Same cycle i_ld_en to index 1 with 32'hDEADBEEF and read 0x4 -> response 32'h00100093; next read 0x4 -> 32'hDEADBEEF.
REQ-039 Two requests outstanding, dready=0, assert i_flush one cycle -> rready=0 that cycle, dvalid=0 next cycle, no stale responses; new request 0x8 -> 32'h00200113.
REQ-040 Drop rstn mid-stream with CNT=2 -> next cycle dvalid=0, rdata=0, rresp=00, rready=0; rstn high -> rready=1, memory contents intact.
